// File: rtl/slot_alloc_if.sv
// Request/response bus between the barcode/keypad front end and the slot translator.
// The slave modport is the translator's view; the master modport is the requester's view.
interface slot_alloc_if #(
    parameter int unsigned N_SLOTS   = 16,
    parameter int unsigned ID_DIGITS = 13,
    parameter int unsigned IDX_W     = 6
);
    localparam int unsigned IDW = 8 * ID_DIGITS;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_op;
    logic                 req_src;
    logic [IDW-1:0]       req_id;
    logic [IDX_W-1:0]     req_idx;
    logic                 rsp_valid;
    logic [1:0]           rsp_status;
    logic [IDX_W-1:0]     rsp_slot;
    logic [IDX_W-1:0]     rsp_row;
    logic [IDX_W-1:0]     rsp_col;
    logic [N_SLOTS-1:0]   occupancy;
    logic [IDX_W:0]       free_count;

    modport slave (
        input  req_valid, req_op, req_src, req_id, req_idx,
        output req_ready, rsp_valid, rsp_status, rsp_slot, rsp_row, rsp_col,
               occupancy, free_count
    );

    modport master (
        output req_valid, req_op, req_src, req_id, req_idx,
        input  req_ready, rsp_valid, rsp_status, rsp_slot, rsp_row, rsp_col,
               occupancy, free_count
    );
endinterface

// File: rtl/slot_alloc_translator.sv
// Table-driven locker slot allocator: saves IDs into the lowest free slot and finds
// them again by ID or by manual index, reporting slot/row/column plus a status code.
module slot_alloc_translator #(
    parameter int unsigned N_SLOTS   = 16,
    parameter int unsigned ID_DIGITS = 13,
    parameter int unsigned COLS      = 4,
    parameter int unsigned IDX_W     = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    slot_alloc_if.slave  bus
);
    localparam int unsigned IDW = 8 * ID_DIGITS;
    localparam int unsigned KW  = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int unsigned CW  = IDX_W + 1;

    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_FULL      = 2'b01;
    localparam logic [1:0] ST_NOT_FOUND = 2'b10;
    localparam logic [1:0] ST_REJECT    = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP} state_e;

    state_e             r_state;
    state_e             w_state_nxt;

    logic [KW-1:0]      r_k;
    logic               r_op;
    logic               r_src;
    logic [IDW-1:0]     r_cap_id;
    logic               r_free_found;
    logic [KW-1:0]      r_free_slot;
    logic               r_match_found;
    logic [KW-1:0]      r_match_slot;

    logic [N_SLOTS-1:0] r_occ;
    logic [N_SLOTS-1:0] r_idv;
    logic [IDW-1:0]     r_tab_id [N_SLOTS];
    logic [CW-1:0]      r_free_cnt;

    logic               r_ready;
    logic               r_rsp_valid;
    logic [1:0]         r_rsp_status;
    logic [IDX_W-1:0]   r_rsp_slot;
    logic [IDX_W-1:0]   r_rsp_row;
    logic [IDX_W-1:0]   r_rsp_col;

    logic               w_hs;
    logic               w_k_free;
    logic               w_k_match;
    logic               w_k_last;
    logic               w_match_any;
    logic [KW-1:0]      w_match_slot;
    logic               w_free_any;
    logic [KW-1:0]      w_free_slot;
    logic               w_idx_ok;
    logic               w_idx_occ;
    logic               w_load_rsp;
    logic [1:0]         w_status_nxt;
    logic [IDX_W-1:0]   w_slot_nxt;
    logic [IDX_W-1:0]   w_row_nxt;
    logic [IDX_W-1:0]   w_col_nxt;
    logic               w_upd;
    logic [KW-1:0]      w_upd_slot;

    assign w_hs      = bus.req_valid & r_ready;
    assign w_k_last  = (r_k == KW'(N_SLOTS - 1));
    assign w_k_free  = ~r_occ[r_k];
    assign w_k_match = r_occ[r_k] & r_idv[r_k] & (r_tab_id[r_k] == r_cap_id);

    // Fold the final scanned entry into the running results so RESP can be entered directly.
    assign w_match_any  = r_match_found | w_k_match;
    assign w_match_slot = r_match_found ? r_match_slot : r_k;
    assign w_free_any   = r_free_found | w_k_free;
    assign w_free_slot  = r_free_found ? r_free_slot : r_k;

    assign w_idx_ok  = (bus.req_idx < IDX_W'(N_SLOTS));
    assign w_idx_occ = w_idx_ok & r_occ[bus.req_idx[KW-1:0]];

    assign w_row_nxt = IDX_W'(w_slot_nxt / IDX_W'(COLS));
    assign w_col_nxt = IDX_W'(w_slot_nxt % IDX_W'(COLS));

    assign w_upd      = (r_state == S_RESP) && (r_rsp_status == ST_OK);
    assign w_upd_slot = r_rsp_slot[KW-1:0];

    // Next-state and response decision.
    always_comb begin
        w_state_nxt  = r_state;
        w_load_rsp   = 1'b0;
        w_status_nxt = ST_OK;
        w_slot_nxt   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_hs) begin
                    if (bus.req_src) begin
                        w_state_nxt = S_RESP;
                        w_load_rsp  = 1'b1;
                        w_slot_nxt  = bus.req_idx;
                        if (!w_idx_ok)
                            w_status_nxt = ST_REJECT;
                        else if (!bus.req_op)
                            w_status_nxt = w_idx_occ ? ST_REJECT : ST_OK;
                        else
                            w_status_nxt = w_idx_occ ? ST_OK : ST_NOT_FOUND;
                    end else begin
                        w_state_nxt = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (w_k_last) begin
                    w_state_nxt = S_RESP;
                    w_load_rsp  = 1'b1;
                    if (!r_op) begin
                        if (w_match_any) begin
                            w_status_nxt = ST_REJECT;
                            w_slot_nxt   = IDX_W'(w_match_slot);
                        end else if (!w_free_any) begin
                            w_status_nxt = ST_FULL;
                        end else begin
                            w_slot_nxt   = IDX_W'(w_free_slot);
                        end
                    end else if (w_match_any) begin
                        w_slot_nxt   = IDX_W'(w_match_slot);
                    end else begin
                        w_status_nxt = ST_NOT_FOUND;
                    end
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control, scan tracking and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_k           <= '0;
            r_op          <= 1'b0;
            r_src         <= 1'b0;
            r_cap_id      <= '0;
            r_free_found  <= 1'b0;
            r_free_slot   <= '0;
            r_match_found <= 1'b0;
            r_match_slot  <= '0;
            r_ready       <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_status  <= ST_OK;
            r_rsp_slot    <= '0;
            r_rsp_row     <= '0;
            r_rsp_col     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ready     <= (w_state_nxt == S_IDLE);
            r_rsp_valid <= w_load_rsp;
            if (w_load_rsp) begin
                r_rsp_status <= w_status_nxt;
                r_rsp_slot   <= w_slot_nxt;
                r_rsp_row    <= w_row_nxt;
                r_rsp_col    <= w_col_nxt;
            end
            if (r_state == S_IDLE && w_hs) begin
                r_op          <= bus.req_op;
                r_src         <= bus.req_src;
                r_cap_id      <= bus.req_id;
                r_k           <= '0;
                r_free_found  <= 1'b0;
                r_match_found <= 1'b0;
            end else if (r_state == S_SCAN) begin
                r_k <= r_k + KW'(1);
                if (!r_free_found && w_k_free) begin
                    r_free_found <= 1'b1;
                    r_free_slot  <= r_k;
                end
                if (!r_match_found && w_k_match) begin
                    r_match_found <= 1'b1;
                    r_match_slot  <= r_k;
                end
            end
        end
    end

    // Slot table; committed on the edge that ends the response cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ      <= '0;
            r_idv      <= '0;
            r_free_cnt <= CW'(N_SLOTS);
            for (int i = 0; i < int'(N_SLOTS); i++) r_tab_id[i] <= '0;
        end else if (w_upd) begin
            if (!r_op) begin
                r_occ[w_upd_slot] <= 1'b1;
                r_idv[w_upd_slot] <= ~r_src;
                if (!r_src) r_tab_id[w_upd_slot] <= r_cap_id;
                r_free_cnt <= r_free_cnt - CW'(1);
            end else begin
                r_occ[w_upd_slot] <= 1'b0;
                r_idv[w_upd_slot] <= 1'b0;
                r_free_cnt <= r_free_cnt + CW'(1);
            end
        end
    end

    assign bus.req_ready  = r_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_status = r_rsp_status;
    assign bus.rsp_slot   = r_rsp_slot;
    assign bus.rsp_row    = r_rsp_row;
    assign bus.rsp_col    = r_rsp_col;
    assign bus.occupancy  = r_occ;
    assign bus.free_count = r_free_cnt;
endmodule

// File: tb/tb_slot_alloc_translator.sv
// Directed bench for slot_alloc_translator: save/fetch by ID and by index, full table,
// reset during a scan and requests ignored while busy.
module tb_slot_alloc_translator;
    localparam int unsigned N     = 16;
    localparam int unsigned IDW   = 104;
    localparam int unsigned IDX_W = 6;

    localparam logic [1:0] OK = 2'b00, FULL = 2'b01, NF = 2'b10, REJ = 2'b11;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    slot_alloc_if #(.N_SLOTS(N), .ID_DIGITS(13), .IDX_W(IDX_W)) bus ();

    slot_alloc_translator #(.N_SLOTS(N), .ID_DIGITS(13), .COLS(4), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]       r_status;
    logic [IDX_W-1:0] r_slot, r_row, r_col;
    int               r_lat;
    logic [IDW-1:0]   id0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request and wait (bounded) for its response pulse.
    task automatic do_req(input logic op, input logic src, input logic [IDW-1:0] id,
                          input logic [IDX_W-1:0] idx);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_src   = src;
        bus.req_id    = id;
        bus.req_idx   = idx;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        r_lat    = 0;
        r_status = 2'bxx;
        r_slot   = 'x;
        r_row    = 'x;
        r_col    = 'x;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                r_lat    = n;
                r_status = bus.rsp_status;
                r_slot   = bus.rsp_slot;
                r_row    = bus.rsp_row;
                r_col    = bus.rsp_col;
                break;
            end
        end
    endtask

    task automatic req_chk(input string tag, input logic op, input logic src,
                           input logic [IDW-1:0] id, input logic [IDX_W-1:0] idx,
                           input logic [1:0] e_st, input int e_slot, input int e_row,
                           input int e_col, input logic [15:0] e_occ, input int e_free);
        do_req(op, src, id, idx);
        chk({tag, "_lat"},    64'(r_lat),    src ? 64'd1 : 64'(N + 1));
        chk({tag, "_status"}, 64'(r_status), 64'(e_st));
        chk({tag, "_slot"},   64'(r_slot),   64'(e_slot));
        chk({tag, "_row"},    64'(r_row),    64'(e_row));
        chk({tag, "_col"},    64'(r_col),    64'(e_col));
        @(negedge clk);
        chk({tag, "_occ"},    64'(bus.occupancy),  64'(e_occ));
        chk({tag, "_free"},   64'(bus.free_count), 64'(e_free));
    endtask

    initial begin
        int fill_slots [10] = '{5, 6, 7, 8, 10, 11, 12, 13, 14, 15};
        logic [15:0] occ_model;
        int          free_model;
        int          seen;

        id0 = 104'h39373837333538393735323930;
        bus.req_valid = 1'b0;
        bus.req_op    = 1'b0;
        bus.req_src   = 1'b0;
        bus.req_id    = '0;
        bus.req_idx   = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready",  64'(bus.req_ready),  64'd1);
        chk("rst_valid",  64'(bus.rsp_valid),  64'd0);
        chk("rst_status", 64'(bus.rsp_status), 64'd0);
        chk("rst_slot",   64'({bus.rsp_slot, bus.rsp_row, bus.rsp_col}), 64'd0);
        chk("rst_occ",    64'(bus.occupancy),  64'd0);
        chk("rst_free",   64'(bus.free_count), 64'd16);

        req_chk("save0", 0, 0, id0,            0, OK,  0, 0, 0, 16'h0001, 15);
        req_chk("save1", 0, 0, id0 + 104'd1,   0, OK,  1, 0, 1, 16'h0003, 14);
        req_chk("save2", 0, 0, id0 + 104'd2,   0, OK,  2, 0, 2, 16'h0007, 13);
        req_chk("save3", 0, 0, id0 + 104'd3,   0, OK,  3, 0, 3, 16'h000F, 12);
        req_chk("save4", 0, 0, id0 + 104'd4,   0, OK,  4, 1, 0, 16'h001F, 11);
        req_chk("dup0",  0, 0, id0,            0, REJ, 0, 0, 0, 16'h001F, 11);
        req_chk("fetch2",1, 0, id0 + 104'd2,   0, OK,  2, 0, 2, 16'h001B, 12);
        req_chk("save80",0, 0, id0 - 104'h100, 0, OK,  2, 0, 2, 16'h001F, 11);
        req_chk("msave9",  0, 1, '0, 9,  OK,  9,  2, 1, 16'h021F, 10);
        req_chk("msave9b", 0, 1, '0, 9,  REJ, 9,  2, 1, 16'h021F, 10);
        req_chk("mfetch20",1, 1, '0, 20, REJ, 20, 5, 0, 16'h021F, 10);
        req_chk("mfetch7", 1, 1, '0, 7,  NF,  7,  1, 3, 16'h021F, 10);
        req_chk("fetchz",  1, 0, '0, 0,  NF,  0,  0, 0, 16'h021F, 10);

        occ_model  = 16'h021F;
        free_model = 10;
        for (int i = 0; i < 10; i++) begin
            occ_model[fill_slots[i]] = 1'b1;
            free_model--;
            req_chk($sformatf("fill%0d", i), 0, 0, id0 - 104'h400 + 104'(i), 0, OK,
                    fill_slots[i], fill_slots[i] / 4, fill_slots[i] % 4, occ_model, free_model);
        end
        req_chk("full",   0, 0, id0 + 104'd9, 0, FULL, 0, 0, 0, 16'hFFFF, 0);
        req_chk("fetchU", 1, 0, id0 + 104'd9, 0, NF,   0, 0, 0, 16'hFFFF, 0);

        // Reset in the middle of a scan.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 1'b1;
        bus.req_src   = 1'b0;
        bus.req_id    = id0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("abort_occ",   64'(bus.occupancy),  64'd0);
        chk("abort_free",  64'(bus.free_count), 64'd16);
        chk("abort_ready", 64'(bus.req_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        chk("abort_norsp", 64'(seen), 64'd0);

        // Second request pulsed while busy must be dropped.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 1'b0;
        bus.req_src   = 1'b0;
        bus.req_id    = id0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("busy_ready", 64'(bus.req_ready), 64'd0);
        repeat (3) @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_id    = id0 + 104'd5;
        @(negedge clk);
        bus.req_valid = 1'b0;
        seen   = 0;
        r_slot = '1;
        for (int n = 0; n < 45; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                seen++;
                r_slot   = bus.rsp_slot;
                r_status = bus.rsp_status;
            end
        end
        chk("busy_count",  64'(seen),           64'd1);
        chk("busy_status", 64'(r_status),       64'(OK));
        chk("busy_slot",   64'(r_slot),         64'd0);
        chk("busy_occ",    64'(bus.occupancy),  64'h0001);
        chk("busy_free",   64'(bus.free_count), 64'd15);

        req_chk("mfetch0", 1, 1, '0,  0, OK, 0, 0, 0, 16'h0000, 16);
        req_chk("fetch0g", 1, 0, id0, 0, NF, 0, 0, 0, 16'h0000, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
